// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count and programmable almost-full/almost-empty flags.
// Optional: define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       data_out,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             full_c, empty_c;
    logic             wr_acc_c, rd_acc_c;
`ifdef SYNC_FIFO_ERR_EN
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
`endif

    // Flags decode from the registered occupancy only.
    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == CW'(0));

    // A full FIFO still takes a write when the same edge frees a slot.
    assign wr_acc_c = wr_en & (~full_c | rd_en);
    assign rd_acc_c = rd_en & ~empty_c;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        overflow_d  = overflow_q | (wr_en & full_c & ~rd_en);
        underflow_d = underflow_q | (rd_en & empty_c);
`endif
        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
`ifdef SYNC_FIFO_ERR_EN
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
`ifdef SYNC_FIFO_ERR_EN
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`endif
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = full_c;
    assign empty        = empty_c;
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
`ifdef SYNC_FIFO_ERR_EN
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [3:0]       count;
`ifdef SYNC_FIFO_ERR_EN
    logic             overflow;
    logic             underflow;
`endif

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      errors = 0;
    int unsigned      checks = 0;

    // Reference model state.
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_valid;
    logic             exp_ovf;
    logic             exp_unf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check_eq("count", 32'(count), 32'(n));
        check_eq("empty", 32'(empty), 32'(n == 0));
        check_eq("full", 32'(full), 32'(n == int'(DEPTH)));
        check_eq("almost_full", 32'(almost_full), 32'(n >= int'(AF)));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= int'(AE)));
        check_eq("rd_valid", 32'(rd_valid), 32'(exp_valid));
        check_eq("data_out", 32'(data_out), 32'(exp_dout));
`ifdef SYNC_FIFO_ERR_EN
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        check_eq("underflow", 32'(underflow), 32'(exp_unf));
`endif
    endtask

    // One clock: drive, update the model with the pre-edge occupancy, then check.
    task automatic step(input logic wr, input logic [WIDTH-1:0] din, input logic rd);
        bit was_full, was_empty, wa, ra;
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        @(posedge clk);
        was_full  = (q.size() == int'(DEPTH));
        was_empty = (q.size() == 0);
        wa = wr && (!was_full || rd);
        ra = rd && !was_empty;
        if (wr && was_full && !rd) exp_ovf = 1'b1;
        if (rd && was_empty)       exp_unf = 1'b1;
        exp_valid = ra;
        if (ra) exp_dout = q.pop_front();
        if (wa) q.push_back(din);
        #1;
        check_all();
    endtask

    int pw;
    int pr;

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Fill 0x11..0x88.
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i * 17), 1'b0);
        check_eq("full_after_fill", 32'(full), 32'd1);
        // Write into full without read is dropped.
        step(1'b1, 8'h99, 1'b0);
        // Drain in order, then one extra read.
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check_eq("drain_word", 32'(data_out), 32'(i * 17));
        end
        step(1'b0, 8'h00, 1'b1);
        check_eq("hold_last", 32'(data_out), 32'h88);

        // Pointer wrap.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

        // Simultaneous at full, then at empty.
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(255)), 1'b0);
        step(1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check_eq("c3_last", 32'(data_out), 32'hC3);
        step(1'b1, 8'h3C, 1'b1);
        check_eq("both_at_empty_valid", 32'(rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-stream at count 4.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hE4, 1'b0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

        // Randomized traffic with shifting write/read bias.
        for (int blk = 0; blk < 16; blk++) begin
            pw = int'($urandom_range(100));
            pr = int'($urandom_range(100));
            for (int c = 0; c < 150; c++) begin
                step(int'($urandom_range(99)) < pw, 8'($urandom_range(255)),
                     int'($urandom_range(99)) < pr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
